// File: rtl/manquehuito_pkg.sv
// manquehuito_pkg: shared fetch-path widths and the entry type carried from fetch to decode.
package manquehuito_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
module fetch_fifo
    import manquehuito_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    output fetch_entry_t  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = cnt_q;
    // Empty head reads as zero so outputs are clean straight out of reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + PW'(push_i);
        rd_d  = flush_i ? '0 : rd_q + PW'(do_pop);
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues the PC to a 1-cycle ROM, queues {pc, instr} for decode, and
// back-pressures the PC with a credit-based stall; a PC load flushes everything younger.
module fetch_queue
    import manquehuito_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               pc_load_i,
    output logic               stall_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic               imem_req_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic [INSTR_W-1:0] dec_instr_o,
    output logic [ADDR_W-1:0]  dec_pc_o,
    output logic [CW-1:0]      count_o
);
    logic              req_vld_q, req_vld_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              empty, push, pop;
    fetch_entry_t      wdata, head;

    // In-flight request holds a reserved slot, so a push can never overflow.
    assign stall_o     = ({1'b0, count_o} + (CW + 1)'(req_vld_q)) >= (CW + 1)'(DEPTH);
    assign imem_addr_o = pc_i;
    assign imem_req_o  = !stall_o && !pc_load_i;
    assign dec_valid_o = !empty && !pc_load_i;
    assign push        = req_vld_q && !pc_load_i;
    assign pop         = dec_valid_o && dec_ready_i;
    assign wdata       = '{pc: req_pc_q, instr: imem_rdata_i};
    assign dec_instr_o = head.instr;
    assign dec_pc_o    = head.pc;

    always_comb begin
        req_vld_d = imem_req_o;
        req_pc_d  = imem_req_o ? pc_i : req_pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_vld_q <= 1'b0;
            req_pc_q  <= '0;
        end else begin
            req_vld_q <= req_vld_d;
            req_pc_q  <= req_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (pc_load_i),
        .push_i  (push),
        .data_i  (wdata),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (empty),
        .count_o (count_o)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a PC register and 1-cycle ROM model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_load = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  target = 8'h00;
    logic [7:0]  pc;
    logic [15:0] rdata;
    logic        stall, imem_req, dec_valid;
    logic [7:0]  imem_addr, dec_pc;
    logic [15:0] dec_instr;
    logic [2:0]  count;
    int          errors = 0;
    int          checks = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pc_i         (pc),
        .pc_load_i    (pc_load),
        .stall_o      (stall),
        .imem_addr_o  (imem_addr),
        .imem_req_o   (imem_req),
        .imem_rdata_i (rdata),
        .dec_valid_o  (dec_valid),
        .dec_ready_i  (ready),
        .dec_instr_o  (dec_instr),
        .dec_pc_o     (dec_pc),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    // PC block: load has priority over stall
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 8'h00;
        else if (pc_load) pc <= target;
        else if (!stall) pc <= pc + 8'h01;
    end

    always @(posedge clk) rdata <= {8'hA5, imem_addr};

    task tick;
        @(posedge clk);
        #1;
    endtask

    task start_run(input logic rdy);
        ready = rdy;
        pc_load = 1'b0;
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task test_reset;
        ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || stall !== 1'b0 || dec_pc !== 8'h00 || dec_instr !== 16'h0000) begin
            errors++;
            $display("FAIL reset: count=%0d valid=%b stall=%b pc=%h instr=%h, want 0 0 0 00 0000", count, dec_valid, stall, dec_pc, dec_instr);
        end
    endtask

    task test_stream;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency1: valid=%b want 0", dec_valid);
        end
        tick;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(k) || dec_instr !== {8'hA5, 8'(k)} || stall !== 1'b0) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h stall=%b, want 1 %h %h 0", k, dec_valid, dec_pc, dec_instr, stall, 8'(k), {8'hA5, 8'(k)});
            end
            tick;
        end
    endtask

    task test_backpressure;
        start_run(1'b0);
        repeat (4) tick;
        checks++;
        if (count !== 3'd3 || stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_credit: count=%0d stall=%b, want 3 1", count, stall);
        end
        tick;
        repeat (3) tick;
        checks++;
        if (count !== 3'd4 || stall !== 1'b1 || pc !== 8'h04) begin
            errors++;
            $display("FAIL bp_full: count=%0d stall=%b pc=%h, want 4 1 04", count, stall, pc);
        end
        ready = 1'b1;
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'h00) begin
            errors++;
            $display("FAIL bp_head: valid=%b pc=%h, want 1 00", dec_valid, dec_pc);
        end
        for (int i = 1; i <= 5; i++) begin
            tick;
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(i) || stall !== 1'b0) begin
                errors++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h stall=%b, want 1 %h 0", i, dec_valid, dec_pc, stall, 8'(i));
            end
        end
    endtask

    task test_flush;
        start_run(1'b0);
        repeat (4) tick;
        pc_load = 1'b1;
        target = 8'h40;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_gate: valid=%b req=%b, want 0 0", dec_valid, imem_req);
        end
        tick;
        pc_load = 1'b0;
        ready = 1'b1;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: count=%0d valid=%b stall=%b, want 0 0 0", count, dec_valid, stall);
        end
        tick;
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_nostale: valid=%b pc=%h, want 0", dec_valid, dec_pc);
        end
        tick;
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'h40 || dec_instr !== 16'hA540) begin
            errors++;
            $display("FAIL flush_target: valid=%b pc=%h instr=%h, want 1 40 A540", dec_valid, dec_pc, dec_instr);
        end
        tick;
        checks++;
        if (dec_pc !== 8'h41 || dec_instr !== 16'hA541) begin
            errors++;
            $display("FAIL flush_next: pc=%h instr=%h, want 41 A541", dec_pc, dec_instr);
        end
    endtask

    task test_back_to_back;
        logic [7:0] exp_pc;
        start_run(1'b0);
        repeat (4) tick;
        exp_pc = 8'h00;
        for (int r = 0; r < 6; r++) begin
            ready = (r % 2 == 0);
            tick;
            if (r % 2 == 0) exp_pc = exp_pc + 8'h01;
            checks++;
            if (count < 3'd3 || count > 3'd4 || dec_pc !== exp_pc || dec_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: count=%0d pc=%h valid=%b, want 3..4 %h 1", r, count, dec_pc, dec_valid, exp_pc);
            end
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            exp_pc = exp_pc + 8'h01;
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== {8'hA5, exp_pc}) begin
                errors++;
                $display("FAIL b2b_order[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, dec_valid, dec_pc, dec_instr, exp_pc, {8'hA5, exp_pc});
            end
        end
    endtask

    task test_async_reset;
        start_run(1'b1);
        repeat (5) tick;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || stall !== 1'b0 || dec_pc !== 8'h00 || dec_instr !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: count=%0d valid=%b stall=%b pc=%h instr=%h, want 0 0 0 00 0000", count, dec_valid, stall, dec_pc, dec_instr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        tick;
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || dec_instr !== 16'hA500) begin
            errors++;
            $display("FAIL async_restart: valid=%b pc=%h instr=%h, want 1 00 A500", dec_valid, dec_pc, dec_instr);
        end
    endtask

    task test_wrap;
        logic [7:0] seq [4];
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ready = 1'b1;
        pc_load = 1'b1;
        target = 8'hFE;
        tick;
        pc_load = 1'b0;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_flush: count=%0d valid=%b, want 0 0", count, dec_valid);
        end
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== seq[i] || dec_instr !== {8'hA5, seq[i]}) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", i, dec_valid, dec_pc, dec_instr, seq[i], {8'hA5, seq[i]});
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_flush;
        test_back_to_back;
        test_async_reset;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
